// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: walks a latched channel mask, runs one saradc conversion per channel and streams results
module sar_scan_sequencer #(
  parameter int NBits         = 5,
  parameter int NChan         = 4,
  parameter int ChanW         = 2,
  parameter int SettleCycles  = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             continuous,
  input  logic [NChan-1:0] chanMask,
  output logic             nStartCnv,
  input  logic             nEndCnv,
  input  logic [NBits-1:0] adcData,
  output logic [ChanW-1:0] muxSel,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [ChanW-1:0] resultChan,
  output logic [NBits-1:0] resultData,
  output logic             busy,
  output logic             scanDone,
  output logic             timeoutErr
);
  localparam logic [1:0] s_idle = 2'd0, s_settle = 2'd1, s_convert = 2'd2, s_output = 2'd3;
  localparam int SW = $clog2(SettleCycles + 1);
  localparam int TW = $clog2(TimeoutCycles);
  localparam logic [SW-1:0] s_last = SW'(SettleCycles);
  localparam logic [TW-1:0] t_last = TW'(TimeoutCycles - 1);
  logic [1:0] state;
  logic [NChan-1:0] mask;
  logic [ChanW-1:0] chan, next_chan, low_chan;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic has_next;
  assign muxSel = chan;
  assign busy = state != s_idle;
  always_comb begin
    next_chan = '0;
    low_chan = '0;
    has_next = 1'b0;
    for (int i = NChan - 1; i >= 0; i--) begin
      if (mask[i] && ChanW'(i) > chan) begin
        next_chan = ChanW'(i);
        has_next = 1'b1;
      end
      if (chanMask[i]) low_chan = ChanW'(i);
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= s_idle;
      mask <= '0;
      chan <= '0;
      scnt <= '0;
      tcnt <= '0;
      nStartCnv <= 1'b1;
      resultValid <= 1'b0;
      resultChan <= '0;
      resultData <= '0;
      scanDone <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      scanDone <= 1'b0;
      case (state)
        s_idle: if (enable && |chanMask) begin
          mask <= chanMask;
          chan <= low_chan;
          timeoutErr <= 1'b0;
          scnt <= '0;
          state <= s_settle;
        end
        // the ADC must be idle (nEndCnv high) before a new start is issued
        s_settle: if (scnt == s_last && nEndCnv) begin
          nStartCnv <= 1'b0;
          tcnt <= '0;
          state <= s_convert;
        end else if (scnt != s_last) begin
          scnt <= scnt + SW'(1);
        end
        s_convert: if (!nEndCnv) begin
          resultData <= adcData;
          resultChan <= chan;
          resultValid <= 1'b1;
          nStartCnv <= 1'b1;
          state <= s_output;
        end else if (tcnt == t_last) begin
          timeoutErr <= 1'b1;
          nStartCnv <= 1'b1;
          state <= s_idle;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        default: if (resultReady) begin
          resultValid <= 1'b0;
          scnt <= '0;
          if (has_next) begin
            chan <= next_chan;
            state <= enable ? s_settle : s_idle;
          end else begin
            scanDone <= 1'b1;
            if (continuous && enable && |chanMask) begin
              mask <= chanMask;
              chan <= low_chan;
              state <= s_settle;
            end else begin
              state <= s_idle;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb_sar_scan_sequencer: directed and randomized scans against a saradc model and an ascending-mask result model
module tb_sar_scan_sequencer;
  localparam int settle = 2;
  localparam int tmo = 64;
  logic clock = 1'b0;
  logic reset, enable, continuous, nEndCnv, resultReady;
  logic [3:0] chanMask;
  logic [4:0] adcData;
  logic nStartCnv, resultValid, busy, scanDone, timeoutErr;
  logic [1:0] muxSel, resultChan;
  logic [4:0] resultData;
  int checks = 0, errors = 0;
  int n_start, n_done, tcyc, first_start_at;
  bit prev_low = 1'b0;
  int got_q[$], exp_q[$], mux_q[$];
  logic [4:0] adc_val [4];
  int adc_lat = 42;
  bit adc_hang = 1'b0;

  sar_scan_sequencer #(.NBits(5), .NChan(4), .ChanW(2), .SettleCycles(settle), .TimeoutCycles(tmo)) dut (
    .clock(clock), .reset(reset), .enable(enable), .continuous(continuous), .chanMask(chanMask),
    .nStartCnv(nStartCnv), .nEndCnv(nEndCnv), .adcData(adcData), .muxSel(muxSel),
    .resultValid(resultValid), .resultReady(resultReady), .resultChan(resultChan),
    .resultData(resultData), .busy(busy), .scanDone(scanDone), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  // saradc model: answers adc_lat cycles after nStartCnv falls, releases once it rises
  initial begin
    int adc_cnt = 0;
    nEndCnv = 1'b1;
    adcData = '0;
    forever begin
      @(negedge clock);
      if (nStartCnv !== 1'b0 || adc_hang) begin
        adc_cnt = 0;
        nEndCnv = 1'b1;
      end else begin
        adc_cnt++;
        if (adc_cnt == adc_lat) begin
          nEndCnv = 1'b0;
          adcData = adc_val[muxSel];
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    n_start = 0;
    n_done = 0;
    tcyc = 0;
    first_start_at = 0;
    got_q.delete();
    mux_q.delete();
    prev_low = (nStartCnv === 1'b0);
  endtask

  task automatic step(input logic rdy);
    @(negedge clock);
    tcyc++;
    if (nStartCnv === 1'b0 && !prev_low) begin
      n_start++;
      mux_q.push_back(int'(muxSel));
      if (n_start == 1) first_start_at = tcyc;
    end
    prev_low = (nStartCnv === 1'b0);
    if (scanDone === 1'b1) n_done++;
    resultReady = rdy;
    if (resultValid === 1'b1 && rdy) got_q.push_back(int'(resultChan) * 256 + int'(resultData));
  endtask

  function automatic void build_exp(input logic [3:0] m);
    exp_q.delete();
    for (int c = 0; c < 4; c++) if (m[c]) exp_q.push_back(c * 256 + int'(adc_val[c]));
  endfunction

  task automatic cmp_results(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk({tag, "_result"}, got_q[i], exp_q[i]);
  endtask

  task automatic run_scan(input int pop, input bit rnd, input bit scramble);
    int cyc = 0;
    do begin
      step(rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (scramble) chanMask = 4'($urandom);
      if (n_start >= pop) enable = 1'b0;
      cyc++;
    end while ((enable || busy === 1'b1) && cyc < 4000);
    chk("scan_bound", cyc < 4000, 1);
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    int n, c;
    bit any_busy;
    logic [3:0] m;
    reset = 1'b0;
    enable = 1'b0;
    continuous = 1'b0;
    chanMask = '0;
    resultReady = 1'b1;
    for (int i = 0; i < 4; i++) adc_val[i] = '0;
    clear_mon();
    repeat (3) step(1'b1);
    chk("rst_nstart", nStartCnv, 1);
    chk("rst_muxsel", muxSel, 0);
    chk("rst_valid", resultValid, 0);
    chk("rst_chan", resultChan, 0);
    chk("rst_data", resultData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scandone", scanDone, 0);
    chk("rst_timeout", timeoutErr, 0);
    reset = 1'b1;
    repeat (2) step(1'b1);

    adc_val[1] = 5'd7;
    adc_val[3] = 5'd20;
    adc_lat = 42;
    clear_mon();
    chanMask = 4'b1010;
    enable = 1'b1;
    build_exp(4'b1010);
    run_scan(2, 1'b0, 1'b0);
    chk("basic_start_latency", first_start_at - 1, settle + 1);
    chk("basic_starts", n_start, 2);
    chk("basic_mux0", mux_q.size() > 0 ? mux_q[0] : -1, 1);
    chk("basic_mux1", mux_q.size() > 1 ? mux_q[1] : -1, 3);
    chk("basic_scandone", n_done, 1);
    chk("basic_busy", busy, 0);
    cmp_results("basic");

    adc_val[3] = 5'($urandom);
    clear_mon();
    chanMask = 4'b1010;
    enable = 1'b1;
    build_exp(4'b1010);
    n = 0;
    while (resultValid !== 1'b1 && n < 200) begin
      step(1'b0);
      n++;
    end
    chk("bp_valid_rise", resultValid, 1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk("bp_hold", {resultValid, resultChan, resultData, nStartCnv}, {1'b1, 2'd1, 5'd7, 1'b1});
    end
    step(1'b1);
    n = 0;
    while (n_start < 2 && n < 40) begin
      step(1'b1);
      n++;
    end
    chk("bp_restart_latency", n - 1, settle + 1);
    run_scan(2, 1'b0, 1'b0);
    chk("bp_scandone", n_done, 1);
    cmp_results("bp");

    adc_val[0] = 5'($urandom);
    adc_lat = 30;
    continuous = 1'b1;
    clear_mon();
    chanMask = 4'b0001;
    enable = 1'b1;
    exp_q.delete();
    repeat (3) exp_q.push_back(int'(adc_val[0]));
    run_scan(3, 1'b0, 1'b0);
    continuous = 1'b0;
    chk("cont_scandone", n_done, 3);
    chk("cont_starts", n_start, 3);
    chk("cont_busy", busy, 0);
    cmp_results("cont");

    adc_hang = 1'b1;
    clear_mon();
    chanMask = 4'b0100;
    enable = 1'b1;
    n = 0;
    while (nStartCnv !== 1'b0 && n < 50) begin
      step(1'b1);
      n++;
    end
    c = 0;
    while (nStartCnv === 1'b0 && c < 200) begin
      c++;
      step(1'b1);
    end
    enable = 1'b0;
    chk("tmo_cycles", c, tmo);
    chk("tmo_flag", timeoutErr, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_nstart", nStartCnv, 1);
    chk("tmo_valid", resultValid, 0);
    repeat (3) step(1'b1);
    chk("tmo_sticky", timeoutErr, 1);
    chk("tmo_no_done", n_done, 0);
    chk("tmo_no_result", got_q.size(), 0);
    adc_hang = 1'b0;
    adc_val[2] = 5'($urandom);
    clear_mon();
    enable = 1'b1;
    step(1'b1);
    chk("tmo_clear", timeoutErr, 0);
    build_exp(4'b0100);
    run_scan(1, 1'b0, 1'b0);
    cmp_results("tmo_rescan");

    adc_val[2] = 5'($urandom);
    adc_val[3] = 5'($urandom);
    chanMask = 4'b1100;
    enable = 1'b1;
    n = 0;
    while (nStartCnv !== 1'b0 && n < 50) begin
      step(1'b1);
      n++;
    end
    repeat (5) step(1'b1);
    reset = 1'b0;
    step(1'b1);
    chk("rstc_nstart", nStartCnv, 1);
    chk("rstc_outputs", {muxSel, resultValid, resultChan, resultData, busy, scanDone, timeoutErr}, 0);
    clear_mon();
    reset = 1'b1;
    build_exp(4'b1100);
    run_scan(2, 1'b0, 1'b0);
    chk("rstc_start_latency", first_start_at - 1, settle + 1);
    chk("rstc_first_chan", mux_q.size() > 0 ? mux_q[0] : -1, 2);
    chk("rstc_scandone", n_done, 1);
    cmp_results("rstc");

    clear_mon();
    chanMask = 4'b0000;
    enable = 1'b1;
    any_busy = 1'b0;
    repeat (20) begin
      step(1'b1);
      any_busy |= (busy !== 1'b0);
    end
    enable = 1'b0;
    chk("empty_busy", any_busy, 0);
    chk("empty_starts", n_start, 0);
    chk("empty_done", n_done, 0);
    chk("empty_timeout", timeoutErr, 0);

    for (int i = 0; i < 4; i++) adc_val[i] = 5'($urandom);
    adc_lat = 20;
    clear_mon();
    chanMask = 4'b1011;
    enable = 1'b1;
    exp_q.delete();
    exp_q.push_back(int'(adc_val[0]));
    run_scan(1, 1'b0, 1'b0);
    chk("drop_no_done", n_done, 0);
    chk("drop_busy", busy, 0);
    cmp_results("drop");

    for (int r = 0; r < 8; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) adc_val[i] = 5'($urandom);
      adc_lat = $urandom_range(1, 40);
      build_exp(m);
      clear_mon();
      chanMask = m;
      enable = 1'b1;
      run_scan($countones(m), 1'b1, 1'b1);
      chk("rand_scandone", n_done, 1);
      chk("rand_starts", n_start, $countones(m));
      cmp_results("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
